alu_nibble_seq: RTL and testbench

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

---
 rtl/alu_nibble_seq.sv | 141 ++++++++++++++
 tb/tb_alu_nibble_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Sequential 74181-style ALU: one 4-bit slice per cycle, ripple carry held in a register.
// Valid/ready request in, valid/ready result out; WIDTH must be a multiple of 4.
`timescale 1ns/1ps

module alu_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             zero,
  output logic             aeqb,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;

  logic [3:0]       an;
  logic [3:0]       bn;
  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       lg;
  logic [3:0]       slice;
  logic [4:0]       sum5;
  logic             c3;
  logic [WIDTH-1:0] f_nxt;

  // Operands shift right each step, so the active nibble is always bits [3:0].
  assign an = a_q[3:0];
  assign bn = b_q[3:0];

  // One 74181 slice: arithmetic result is X + Y + carry, logic result is a bitwise function.
  always_comb begin
    x     = an | (bn & {4{s_q[0]}}) | (~bn & {4{s_q[1]}});
    y     = (an & bn & {4{s_q[3]}}) | (an & ~bn & {4{s_q[2]}});
    sum5  = 5'(x) + 5'(y) + 5'(carry);
    c3    = x[3] ^ y[3] ^ sum5[3];
    lg    = 4'h0;
    case (s_q)
      4'd0:  lg = ~an;
      4'd1:  lg = ~(an | bn);
      4'd2:  lg = ~an & bn;
      4'd3:  lg = 4'h0;
      4'd4:  lg = ~(an & bn);
      4'd5:  lg = ~bn;
      4'd6:  lg = an ^ bn;
      4'd7:  lg = an & ~bn;
      4'd8:  lg = ~an | bn;
      4'd9:  lg = ~(an ^ bn);
      4'd10: lg = bn;
      4'd11: lg = an & bn;
      4'd12: lg = 4'hF;
      4'd13: lg = an | ~bn;
      4'd14: lg = an | bn;
      default: lg = an;
    endcase
    slice = m_q ? lg : sum5[3:0];
    f_nxt = (f >> 4) | (WIDTH'(slice) << (WIDTH - 4));
  end

  // Control FSM and all registered outputs; result nibbles shift in from the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= 4'h0;
      m_q       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      f         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      aeqb      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            s_q      <= s;
            m_q      <= m;
            carry    <= ~m & c_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          f     <= f_nxt;
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          carry <= sum5[4];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            c_out     <= ~m_q & sum5[4];
            ovf       <= ~m_q & (c3 ^ sum5[4]);
            zero      <= (f_nxt == '0);
            aeqb      <= &f_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed plus random bench for alu_nibble_seq at WIDTH=16 with a result scoreboard.
`timescale 1ns/1ps

module tb_alu_nibble_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  s;
  logic        m;
  logic        c_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        c_out;
  logic        zero;
  logic        aeqb;
  logic        ovf;

  typedef struct {
    logic [15:0] f;
    logic        c_out;
    logic        zero;
    logic        aeqb;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .m(m), .c_in(c_in), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .c_out(c_out), .zero(zero), .aeqb(aeqb), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width result straight from the function tables.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic [3:0] ts, input logic tm, input logic tc);
    exp_t        e;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [16:0] sum;
    o1 = 16'h0;
    o2 = 16'h0;
    e.c_out = 1'b0;
    e.ovf   = 1'b0;
    if (tm) begin
      case (ts)
        4'd0:  e.f = ~ta;
        4'd1:  e.f = ~(ta | tb);
        4'd2:  e.f = ~ta & tb;
        4'd3:  e.f = 16'h0000;
        4'd4:  e.f = ~(ta & tb);
        4'd5:  e.f = ~tb;
        4'd6:  e.f = ta ^ tb;
        4'd7:  e.f = ta & ~tb;
        4'd8:  e.f = ~ta | tb;
        4'd9:  e.f = ~(ta ^ tb);
        4'd10: e.f = tb;
        4'd11: e.f = ta & tb;
        4'd12: e.f = 16'hFFFF;
        4'd13: e.f = ta | ~tb;
        4'd14: e.f = ta | tb;
        default: e.f = ta;
      endcase
    end else begin
      case (ts)
        4'd0:  begin o1 = ta;        o2 = 16'h0000;  end
        4'd1:  begin o1 = ta | tb;   o2 = 16'h0000;  end
        4'd2:  begin o1 = ta | ~tb;  o2 = 16'h0000;  end
        4'd3:  begin o1 = 16'hFFFF;  o2 = 16'h0000;  end
        4'd4:  begin o1 = ta;        o2 = ta & ~tb;  end
        4'd5:  begin o1 = ta | tb;   o2 = ta & ~tb;  end
        4'd6:  begin o1 = ta;        o2 = ~tb;       end
        4'd7:  begin o1 = ta & ~tb;  o2 = 16'hFFFF;  end
        4'd8:  begin o1 = ta;        o2 = ta & tb;   end
        4'd9:  begin o1 = ta;        o2 = tb;        end
        4'd10: begin o1 = ta | ~tb;  o2 = ta & tb;   end
        4'd11: begin o1 = ta & tb;   o2 = 16'hFFFF;  end
        4'd12: begin o1 = ta;        o2 = ta;        end
        4'd13: begin o1 = ta | tb;   o2 = ta;        end
        4'd14: begin o1 = ta | ~tb;  o2 = ta;        end
        default: begin o1 = ta;      o2 = 16'hFFFF;  end
      endcase
      sum     = 17'(o1) + 17'(o2) + 17'(tc);
      e.f     = sum[15:0];
      e.c_out = sum[16];
      e.ovf   = (o1[15] == o2[15]) && (sum[15] != o1[15]);
    end
    e.zero = (e.f == 16'h0000);
    e.aeqb = &e.f;
    return e;
  endfunction

  // Issue one request, check latency and result, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [3:0] ts, input logic tm, input logic tc,
                        input int hold, input bit early);
    int   waitc;
    int   lat;
    exp_t e;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
    sb.push_back(model(ta, tb, ts, tm, tc));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    s         = 4'($urandom);
    m         = ~tm;
    c_in      = ~tc;
    out_ready = early;
    chk({tag, "/busy_in_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 3 * N + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(N));
    chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    e = sb.pop_front();
    chk({tag, "/f"}, 32'(f), 32'(e.f));
    chk({tag, "/c_out"}, 32'(c_out), 32'(e.c_out));
    chk({tag, "/zero"}, 32'(zero), 32'(e.zero));
    chk({tag, "/aeqb"}, 32'(aeqb), 32'(e.aeqb));
    chk({tag, "/ovf"}, 32'(ovf), 32'(e.ovf));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "/hold_f"}, 32'(f), 32'(e.f));
      chk({tag, "/hold_flags"}, 32'({c_out, zero, aeqb, ovf}),
          32'({e.c_out, e.zero, e.aeqb, e.ovf}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s = 4'h0; m = 1'b0; c_in = 1'b0; a = 16'h0; b = 16'h0;
    #1;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/f", 32'(f), 32'd0);
    chk("reset/flags", 32'({c_out, zero, aeqb, ovf}), 32'b0100);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_op("add",       16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub",       16'h1234, 16'h0FFF, 4'b0110, 1'b0, 1'b1, 0, 1'b1);
    run_op("sub_neg",   16'h0FFF, 16'h1234, 4'b0110, 1'b0, 1'b1, 0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 1'b1);
    run_op("xor",       16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 0, 1'b0);
    run_op("ones_hold", 16'hF0F0, 16'hFF00, 4'b1100, 1'b1, 1'b1, 3, 1'b0);
    run_op("dec_zero",  16'h0000, 16'h5A5A, 4'b1111, 1'b0, 1'b0, 0, 1'b0);

    // Abort an operation in its second busy cycle.
    a = 16'h1234; b = 16'h4321; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    chk("abort/f", 32'(f), 32'd0);
    chk("abort/zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("post_abort", 16'hABCD, 16'h1111, 4'b1001, 1'b0, 1'b1, 0, 1'b0);
    chk("post_abort/no_extra", 32'(out_valid), 32'd0);

    for (int k = 0; k < 32; k++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
